// File: rtl/soft_tbm_daq_framer.sv
// Frames soft-TBM daq words into sop/eop-marked events inside a FWFT FIFO that never overflows.
// Optional build macro DAQ_FRAMER_STATS_EN enables the evt/trunc/skip statistics counters.
module soft_tbm_daq_framer #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          daq_write,
    input  logic [15:0]   daq_data,
    output logic [15:0]   dout,
    output logic          dout_sop,
    output logic          dout_eop,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [AW:0]   fill,
    output logic [15:0]   evt_cnt,
    output logic [15:0]   trunc_cnt,
    output logic [15:0]   skip_cnt
);

    localparam int          DEPTH        = 2 ** AW;
    localparam logic [AW:0] FILL_HDR_MAX = (AW + 1)'(DEPTH - 2);
    localparam logic [AW:0] FILL_LAST    = (AW + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_TRUNC, ST_SKIP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [17:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_fill;
    logic            w_hdr;
    logic            w_trl;
    logic            w_push;
    logic            w_pop;
    logic [17:0]     w_word;

    assign w_hdr = (daq_data[15:12] == 4'hA);
    assign w_trl = (daq_data[15:12] == 4'hC);

    // Framing decisions look at the occupancy before this edge; a FRAME data word
    // never takes the last slot so any open frame can always write its trailer.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_push      = 1'b0;
        w_word      = 18'd0;
        w_state_nxt = r_state;
        if (daq_write && !clear) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hdr) begin
                        if (r_fill <= FILL_HDR_MAX) begin
                            w_push      = 1'b1;
                            w_word      = {1'b1, 1'b0, daq_data};
                            w_state_nxt = ST_FRAME;
                        end else begin
                            w_state_nxt = ST_SKIP;
                        end
                    end
                end
                ST_FRAME: begin
                    if (w_trl) begin
                        w_push      = 1'b1;
                        w_word      = {1'b0, 1'b1, daq_data};
                        w_state_nxt = ST_IDLE;
                    end else if (w_hdr) begin
                        w_push      = 1'b1;
                        w_word      = {1'b0, 1'b1, 16'hC400};
                        w_state_nxt = ST_SKIP;
                    end else if (r_fill < FILL_LAST) begin
                        w_push      = 1'b1;
                        w_word      = {1'b0, 1'b0, daq_data};
                    end else begin
                        w_state_nxt = ST_TRUNC;
                    end
                end
                ST_TRUNC: begin
                    if (w_trl) begin
                        w_push      = 1'b1;
                        w_word      = {1'b0, 1'b1, daq_data | 16'h0800};
                        w_state_nxt = ST_IDLE;
                    end else if (w_hdr) begin
                        w_push      = 1'b1;
                        w_word      = {1'b0, 1'b1, 16'hCC00};
                        w_state_nxt = ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    if (w_trl) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: all sequential state is updated with non-blocking assignments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else if (clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_pop = dout_valid && dout_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    // NOTE: storage is not reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_word;
    end

    assign fill       = r_fill;
    assign dout_valid = (r_fill != '0);
    assign {dout_sop, dout_eop, dout} = dout_valid ? r_mem[r_rd_ptr] : 18'd0;

`ifdef DAQ_FRAMER_STATS_EN
    logic [15:0] r_evt_cnt;
    logic [15:0] r_trunc_cnt;
    logic [15:0] r_skip_cnt;
    logic        w_act;
    logic        w_evt_inc;
    logic        w_trunc_inc;
    logic        w_skip_inc;

    assign w_act       = daq_write && !clear;
    assign w_evt_inc   = w_act && (r_state == ST_FRAME) && w_trl;
    assign w_trunc_inc = w_act && (r_state == ST_TRUNC) && (w_trl || w_hdr);
    // Orphan words and dropped headers both count as skips.
    assign w_skip_inc  = w_act && (((r_state == ST_IDLE) && (!w_hdr || (r_fill > FILL_HDR_MAX)))
                                   || ((r_state == ST_FRAME) && w_hdr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_evt_cnt   <= '0;
            r_trunc_cnt <= '0;
            r_skip_cnt  <= '0;
        end else begin
            if (w_evt_inc   && (r_evt_cnt   != 16'hFFFF)) r_evt_cnt   <= r_evt_cnt + 1'b1;
            if (w_trunc_inc && (r_trunc_cnt != 16'hFFFF)) r_trunc_cnt <= r_trunc_cnt + 1'b1;
            if (w_skip_inc  && (r_skip_cnt  != 16'hFFFF)) r_skip_cnt  <= r_skip_cnt + 1'b1;
        end
    end

    assign evt_cnt   = r_evt_cnt;
    assign trunc_cnt = r_trunc_cnt;
    assign skip_cnt  = r_skip_cnt;
`else
    assign evt_cnt   = 16'd0;
    assign trunc_cnt = 16'd0;
    assign skip_cnt  = 16'd0;
`endif

endmodule
